dma_mc: RTL and testbench

Multi-channel descriptor-chained DMA engine; parametrised successor to the single-channel DMA on the peripheral bus. It holds NUM_CH independent channels, each with its own control/status registers, descriptor chain and interrupt. The channels share one read/write master port through round-robin arbitration at descriptor granularity. The block sits on the slave memory interface for configuration and on the bus master wrapper for data movement.

---
 rtl/dma_mc_pkg.sv | 34 +++
 rtl/dma_mc_rr_arb.sv | 48 ++++
 rtl/dma_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_dma_mc.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_mc_pkg.sv
// Shared encodings for the multi-channel DMA: engine state codes, register
// offsets within a channel's 4-word window, STATUS/CTRL bit positions and descriptor layout.
package dma_mc_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARB     = 3'd1;
    localparam logic [2:0] ST_DESC_RD = 3'd2;
    localparam logic [2:0] ST_CHECK   = 3'd3;
    localparam logic [2:0] ST_RD      = 3'd4;
    localparam logic [2:0] ST_WR      = 3'd5;
    localparam logic [2:0] ST_NEXT    = 3'd6;

    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_DESC_BASE = 2'd1;
    localparam logic [1:0] REG_STATUS    = 2'd2;
    localparam logic [1:0] REG_CLR       = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IE  = 1;

    localparam int STS_BUSY  = 0;
    localparam int STS_DONE  = 1;
    localparam int STS_ERR   = 2;
    localparam int STS_ABORT = 3;

    // Descriptor word order in memory: base+0/4/8/12.
    localparam logic [1:0] DESC_SRC  = 2'd0;
    localparam logic [1:0] DESC_DST  = 2'd1;
    localparam logic [1:0] DESC_LEN  = 2'd2;
    localparam logic [1:0] DESC_NEXT = 2'd3;

    localparam int EOC_BIT = 0;

endpackage

// File: rtl/dma_mc_rr_arb.sv
// Round-robin arbiter: grants the lowest-index requester at or after
// last_grant+1 (mod N); last_grant advances only when the grant is taken.
module dma_mc_rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          take,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        // Walk offsets from far to near so the nearest requester overrides.
        for (int off = N; off >= 1; off--) begin
            cand = IW'((int'(last_q) + off) % N);
            if (req[cand]) begin
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (take && gnt_valid) begin
            last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dma_mc.sv
// Multi-channel descriptor-chained DMA: per-channel register banks feeding one
// shared copy engine that alternates single-beat reads and writes on the master port.
module dma_mc
    import dma_mc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RA_W   = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [NUM_CH-1:0] irq,
    output logic              R_req,
    output logic [ADDR_W-1:0] AR_ADDR,
    input  logic [DATA_W-1:0] R_DATA,
    input  logic              R_valid,
    output logic              W_req,
    output logic [ADDR_W-1:0] AW_ADDR,
    output logic [DATA_W-1:0] W_DATA,
    input  logic              W_done,
    input  logic              CEB,
    input  logic              WEB,
    input  logic [RA_W-1:0]   A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BPB  = DATA_W / 8;

    // Handshake: R_req/W_req rise from a registered low state with address and
    // data already registered; they stay high until the R_valid/W_done pulse is
    // sampled, then drop for at least one cycle before the next request.

    // Per-channel register state
    logic [NUM_CH-1:0] en_q, en_d, ie_q, ie_d;
    logic [NUM_CH-1:0] busy_q, busy_d, done_q, done_d, err_q, err_d, abort_q, abort_d;
    logic [ADDR_W-1:0] base_q [NUM_CH];
    logic [ADDR_W-1:0] base_d [NUM_CH];
    logic [ADDR_W-1:0] ptr_q  [NUM_CH];
    logic [ADDR_W-1:0] ptr_d  [NUM_CH];
    logic [31:0]       do_q, do_d;

    // Engine state
    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   cur_q, cur_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] desc_q [4];
    logic [ADDR_W-1:0] desc_d [4];
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              r_req_q, r_req_d, w_req_q, w_req_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;

    // Engine events, all aimed at channel cur_q
    logic ev_done, ev_err, ev_abort, ev_stop, ev_clr_en, ev_ptr_we;

    logic [NUM_CH-1:0] pending;
    logic              arb_take;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_valid;

    logic [CH_W-1:0] reg_ch;
    logic [1:0]      reg_k;
    logic            reg_hit, wr_en, rd_en;

    assign reg_k   = A[1:0];
    assign reg_ch  = CH_W'(A >> 2);
    assign reg_hit = (int'(A >> 2) < NUM_CH);
    assign wr_en   = !CEB && !WEB && reg_hit;
    assign rd_en   = !CEB && WEB;

    assign pending = busy_q & en_q;

    dma_mc_rr_arb #(.N(NUM_CH), .IW(CH_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (pending),
        .take      (arb_take),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        r_req_d   = r_req_q;
        w_req_d   = w_req_q;
        ar_addr_d = ar_addr_q;
        aw_addr_d = aw_addr_q;
        for (int i = 0; i < 4; i++) begin
            desc_d[i] = desc_q[i];
        end
        arb_take  = 1'b0;
        ev_done   = 1'b0;
        ev_err    = 1'b0;
        ev_abort  = 1'b0;
        ev_stop   = 1'b0;
        ev_clr_en = 1'b0;
        ev_ptr_we = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (gnt_valid) begin
                    arb_take  = 1'b1;
                    cur_d     = gnt_idx;
                    idx_d     = 2'd0;
                    r_req_d   = 1'b1;
                    ar_addr_d = ptr_q[gnt_idx];
                    state_d   = ST_DESC_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DESC_RD: begin
                if (r_req_q) begin
                    if (R_valid) begin
                        desc_d[idx_q] = ADDR_W'(R_DATA);
                        r_req_d       = 1'b0;
                        idx_d         = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = ST_CHECK;
                        end
                    end
                end else begin
                    r_req_d   = 1'b1;
                    ar_addr_d = ptr_q[cur_q] + ADDR_W'({idx_q, 2'b00});
                end
            end
            ST_CHECK: begin
                if (!en_q[cur_q]) begin
                    ev_abort = 1'b1;
                    ev_stop  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (desc_q[DESC_LEN] == '0 ||
                             (desc_q[DESC_LEN] & ADDR_W'(BPB - 1)) != '0) begin
                    ev_err  = 1'b1;
                    ev_stop = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (r_req_q) begin
                    if (R_valid) begin
                        data_d  = R_DATA;
                        r_req_d = 1'b0;
                        state_d = ST_WR;
                    end
                end else begin
                    r_req_d   = 1'b1;
                    ar_addr_d = desc_q[DESC_SRC] + cnt_q;
                end
            end
            ST_WR: begin
                if (w_req_q) begin
                    if (W_done) begin
                        w_req_d = 1'b0;
                        cnt_d   = cnt_q + ADDR_W'(BPB);
                        // EN dropped mid-beat: this beat is done, stop here.
                        if (!en_q[cur_q]) begin
                            ev_abort = 1'b1;
                            ev_stop  = 1'b1;
                            state_d  = ST_IDLE;
                        end else if (cnt_q + ADDR_W'(BPB) == desc_q[DESC_LEN]) begin
                            state_d = ST_NEXT;
                        end else begin
                            state_d = ST_RD;
                        end
                    end
                end else begin
                    w_req_d   = 1'b1;
                    aw_addr_d = desc_q[DESC_DST] + cnt_q;
                end
            end
            ST_NEXT: begin
                if (desc_q[DESC_NEXT][EOC_BIT]) begin
                    ev_done   = 1'b1;
                    ev_stop   = 1'b1;
                    ev_clr_en = 1'b1;
                end else if (!en_q[cur_q]) begin
                    ev_abort = 1'b1;
                    ev_stop  = 1'b1;
                end else begin
                    ev_ptr_we = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                r_req_d = 1'b0;
                w_req_d = 1'b0;
            end
        endcase
    end

    // Channel register updates: host writes merged with engine events.
    logic       sel, eng, mine, start, uabort;
    logic [2:0] clr;

    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        abort_d = abort_q;
        sel     = 1'b0;
        eng     = 1'b0;
        mine    = 1'b0;
        start   = 1'b0;
        uabort  = 1'b0;
        clr     = 3'b000;
        for (int c = 0; c < NUM_CH; c++) begin
            base_d[c] = base_q[c];
            ptr_d[c]  = ptr_q[c];
            sel  = wr_en && (reg_ch == CH_W'(c));
            mine = (state_q != ST_IDLE) && (cur_q == CH_W'(c));
            // A channel the engine holds (or is granting now) aborts via the
            // engine at a beat boundary; otherwise the abort is immediate.
            eng  = (state_q == ST_ARB) ? (gnt_valid && gnt_idx == CH_W'(c))
                                       : mine;
            start  = sel && reg_k == REG_CTRL && DI[CTRL_EN] && !en_q[c] &&
                     !busy_q[c] && base_q[c] != '0;
            uabort = sel && reg_k == REG_CTRL && !DI[CTRL_EN] && en_q[c] &&
                     busy_q[c] && !eng;
            clr    = (sel && reg_k == REG_CLR) ? DI[STS_ABORT:STS_DONE] : 3'b000;

            if (sel && reg_k == REG_CTRL) begin
                en_d[c] = DI[CTRL_EN];
                ie_d[c] = DI[CTRL_IE];
            end else if (mine && ev_clr_en) begin
                en_d[c] = 1'b0;
            end
            if (sel && reg_k == REG_DESC_BASE) begin
                base_d[c] = ADDR_W'(DI);
            end
            if (start) begin
                ptr_d[c]  = base_q[c];
                busy_d[c] = 1'b1;
            end
            if (mine && ev_ptr_we) begin
                ptr_d[c] = desc_q[DESC_NEXT] & ~ADDR_W'(3);
            end
            if ((mine && ev_stop) || uabort) begin
                busy_d[c] = 1'b0;
            end
            done_d[c]  = (done_q[c]  | (mine && ev_done))              & ~clr[0];
            err_d[c]   = (err_q[c]   | (mine && ev_err))               & ~clr[1];
            abort_d[c] = (abort_q[c] | (mine && ev_abort) | uabort)    & ~clr[2];
        end
    end

    always_comb begin
        do_d = do_q;
        if (rd_en) begin
            do_d = '0;
            if (reg_hit) begin
                case (reg_k)
                    REG_CTRL:      do_d = {30'b0, ie_q[reg_ch], en_q[reg_ch]};
                    REG_DESC_BASE: do_d = 32'(base_q[reg_ch]);
                    REG_STATUS:    do_d = {28'b0, abort_q[reg_ch], err_q[reg_ch],
                                           done_q[reg_ch], busy_q[reg_ch]};
                    default:       do_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= '0;
            ie_q      <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            abort_q   <= '0;
            do_q      <= '0;
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            r_req_q   <= 1'b0;
            w_req_q   <= 1'b0;
            ar_addr_q <= '0;
            aw_addr_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= '0;
                ptr_q[c]  <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                desc_q[i] <= '0;
            end
        end else begin
            en_q      <= en_d;
            ie_q      <= ie_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            do_q      <= do_d;
            state_q   <= state_d;
            cur_q     <= cur_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            r_req_q   <= r_req_d;
            w_req_q   <= w_req_d;
            ar_addr_q <= ar_addr_d;
            aw_addr_q <= aw_addr_d;
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= base_d[c];
                ptr_q[c]  <= ptr_d[c];
            end
            for (int i = 0; i < 4; i++) begin
                desc_q[i] <= desc_d[i];
            end
        end
    end

    assign irq     = ie_q & (done_q | err_q | abort_q);
    assign R_req   = r_req_q;
    assign AR_ADDR = ar_addr_q;
    assign W_req   = w_req_q;
    assign AW_ADDR = aw_addr_q;
    assign W_DATA  = data_q;
    assign DO      = do_q;

endmodule

// File: tb/tb_dma_mc.sv
// Directed bench for dma_mc: a memory responder on the master port, register
// driver tasks, and one task per scenario with hand-computed expectations.
module tb_dma_mc;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RA_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] irq;
    logic              R_req, R_valid, W_req, W_done;
    logic [ADDR_W-1:0] AR_ADDR, AW_ADDR;
    logic [DATA_W-1:0] R_DATA, W_DATA;
    logic              CEB, WEB;
    logic [RA_W-1:0]   A;
    logic [31:0]       DI, DO;

    dma_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst), .irq(irq),
        .R_req(R_req), .AR_ADDR(AR_ADDR), .R_DATA(R_DATA), .R_valid(R_valid),
        .W_req(W_req), .AW_ADDR(AW_ADDR), .W_DATA(W_DATA), .W_done(W_done),
        .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_addr_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [63:0] exp_q [$];
    int          r_cnt, w_cnt, irq_rise0;
    bit          hold_w;
    logic [NUM_CH-1:0] irq_prev;
    int          n_total, n_pass;

    // Memory responder: valid/done pulse two negedges after req is seen.
    initial begin
        R_valid = 1'b0; W_done = 1'b0; R_DATA = '0;
        r_cnt = 0; w_cnt = 0; irq_rise0 = 0; irq_prev = '0;
        forever begin
            @(negedge clk);
            R_valid = 1'b0;
            W_done  = 1'b0;
            if (rst) begin
                r_cnt = 0; w_cnt = 0; irq_prev = '0;
            end else begin
                if (R_req) begin
                    r_cnt++;
                    if (r_cnt == 2) begin
                        R_valid = 1'b1;
                        R_DATA  = mem[AR_ADDR[11:2]];
                        rd_addr_q.push_back(AR_ADDR);
                        r_cnt = 0;
                    end
                end else begin
                    r_cnt = 0;
                end
                if (W_req && !hold_w) begin
                    w_cnt++;
                    if (w_cnt == 2) begin
                        W_done = 1'b1;
                        mem[AW_ADDR[11:2]] = W_DATA;
                        wr_addr_q.push_back(AW_ADDR);
                        wr_data_q.push_back(W_DATA);
                        w_cnt = 0;
                    end
                end else begin
                    w_cnt = 0;
                end
                if (irq[0] && !irq_prev[0]) irq_rise0++;
                irq_prev = irq;
            end
        end
    end

    task automatic reg_write(input logic [RA_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        CEB = 1'b0; WEB = 1'b0; A = a; DI = d;
        @(negedge clk);
        CEB = 1'b1; WEB = 1'b1;
    endtask

    task automatic reg_read(input logic [RA_W-1:0] a, output logic [31:0] d);
        @(negedge clk);
        CEB = 1'b0; WEB = 1'b1; A = a;
        @(negedge clk);
        CEB = 1'b1;
        d = DO;
    endtask

    task automatic put_desc(input int base, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] len, input logic [31:0] nxt);
        mem[base/4]     = src;
        mem[base/4 + 1] = dst;
        mem[base/4 + 2] = len;
        mem[base/4 + 3] = nxt;
    endtask

    task automatic clear_logs();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input int ch, input string name);
        logic [31:0] s;
        int k;
        s = 32'h1;
        k = 0;
        while (s[0] && k < 400) begin
            reg_read(RA_W'(ch * 4 + 2), s);
            k++;
        end
        n_total++;
        if (s[0]) $display("FAIL %s_timeout: busy=%0d after %0d polls, required 0", name, s[0], k);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1;
        n_total++;
        if ({R_req, W_req, irq, DO} !== '0) $display("FAIL rst_outputs: got R=%0b W=%0b irq=%b DO=%h, required all 0", R_req, W_req, irq, DO);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rst_status0: got %h, required 0", d); else n_pass++;
        reg_read(RA_W'(6), d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rst_status1: got %h, required 0", d); else n_pass++;
        reg_read(RA_W'(0), d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rst_ctrl0: got %h, required 0", d); else n_pass++;
    endtask

    task automatic test_single();
        logic [31:0] d;
        clear_logs();
        put_desc(32'h40, 32'h100, 32'h200, 32'd16, 32'h1);
        for (int i = 0; i < 4; i++) exp_q.push_back({32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
        reg_write(RA_W'(1), 32'h40);
        reg_write(RA_W'(0), 32'h3);
        n_total++;
        if (R_req !== 1'b0) $display("FAIL single_early_req: got %0b, required 0", R_req); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (R_req !== 1'b1 || AR_ADDR !== 32'h40)
            $display("FAIL single_first_req: got R_req=%0b addr=%h, required 1 / 00000040", R_req, AR_ADDR);
        else n_pass++;
        wait_idle(0, "single");
        n_total++;
        if (wr_addr_q.size() !== exp_q.size())
            $display("FAIL single_beats: got %0d writes, required %0d", wr_addr_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
            n_total++;
            if ({wr_addr_q[i], wr_data_q[i]} !== exp_q[i])
                $display("FAIL single_wr%0d: got %h/%h, required %h", i, wr_addr_q[i], wr_data_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (rd_addr_q.size() !== 8) $display("FAIL single_reads: got %0d, required 8", rd_addr_q.size()); else n_pass++;
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h2) $display("FAIL single_status: got %h, required 2", d); else n_pass++;
        n_total++;
        if (irq !== 2'b01) $display("FAIL single_irq: got %b, required 01", irq); else n_pass++;
        reg_read(RA_W'(0), d);
        n_total++;
        if (d !== 32'h2) $display("FAIL single_ctrl: got %h, required 2 (EN cleared)", d); else n_pass++;
        reg_write(RA_W'(3), 32'hE);
        @(negedge clk);
        n_total++;
        if (irq !== 2'b00) $display("FAIL single_irq_clr: got %b, required 00", irq); else n_pass++;
    endtask

    task automatic test_chain();
        logic [31:0] d;
        clear_logs();
        irq_rise0 = 0;
        put_desc(32'h40, 32'h100, 32'h300, 32'd8, 32'h80);
        put_desc(32'h80, 32'h180, 32'h380, 32'd4, 32'h1);
        exp_q.push_back({32'h300, 32'hA000_0000});
        exp_q.push_back({32'h304, 32'hA000_0001});
        exp_q.push_back({32'h380, 32'hA000_0020});
        reg_write(RA_W'(1), 32'h40);
        reg_write(RA_W'(0), 32'h3);
        wait_idle(0, "chain");
        n_total++;
        if (wr_addr_q.size() !== exp_q.size())
            $display("FAIL chain_beats: got %0d writes, required %0d", wr_addr_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
            n_total++;
            if ({wr_addr_q[i], wr_data_q[i]} !== exp_q[i])
                $display("FAIL chain_wr%0d: got %h/%h, required %h", i, wr_addr_q[i], wr_data_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (irq_rise0 !== 1) $display("FAIL chain_done_count: got %0d irq edges, required 1", irq_rise0); else n_pass++;
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h2) $display("FAIL chain_status: got %h, required 2", d); else n_pass++;
        reg_write(RA_W'(3), 32'hE);
    endtask

    task automatic test_round_robin();
        logic [31:0] d;
        clear_logs();
        put_desc(32'h40, 32'h100, 32'h200, 32'd4, 32'h50);
        put_desc(32'h50, 32'h104, 32'h210, 32'd4, 32'h1);
        put_desc(32'hC0, 32'h140, 32'h280, 32'd4, 32'hD0);
        put_desc(32'hD0, 32'h144, 32'h290, 32'd4, 32'h1);
        exp_q.push_back({32'h200, 32'hA000_0000});
        exp_q.push_back({32'h280, 32'hA000_0010});
        exp_q.push_back({32'h210, 32'hA000_0001});
        exp_q.push_back({32'h290, 32'hA000_0011});
        reg_write(RA_W'(1), 32'h40);
        reg_write(RA_W'(5), 32'hC0);
        reg_write(RA_W'(0), 32'h1);
        reg_write(RA_W'(4), 32'h1);
        wait_idle(0, "rr_ch0");
        wait_idle(1, "rr_ch1");
        n_total++;
        if (wr_addr_q.size() !== exp_q.size())
            $display("FAIL rr_beats: got %0d writes, required %0d", wr_addr_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
            n_total++;
            if ({wr_addr_q[i], wr_data_q[i]} !== exp_q[i])
                $display("FAIL rr_order%0d: got %h/%h, required %h", i, wr_addr_q[i], wr_data_q[i], exp_q[i]);
            else n_pass++;
        end
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h2) $display("FAIL rr_status0: got %h, required 2", d); else n_pass++;
        reg_read(RA_W'(6), d);
        n_total++;
        if (d !== 32'h2) $display("FAIL rr_status1: got %h, required 2", d); else n_pass++;
        n_total++;
        if (irq !== 2'b00) $display("FAIL rr_irq_masked: got %b, required 00", irq); else n_pass++;
        reg_write(RA_W'(3), 32'hE);
        reg_write(RA_W'(7), 32'hE);
    endtask

    task automatic test_len_err();
        logic [31:0] d;
        clear_logs();
        put_desc(32'h40, 32'h100, 32'h200, 32'd6, 32'h1);
        reg_write(RA_W'(1), 32'h40);
        reg_write(RA_W'(0), 32'h3);
        wait_idle(0, "err");
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h4) $display("FAIL err_status: got %h, required 4", d); else n_pass++;
        n_total++;
        if (rd_addr_q.size() !== 4 || wr_addr_q.size() !== 0)
            $display("FAIL err_traffic: got %0d reads %0d writes, required 4 / 0", rd_addr_q.size(), wr_addr_q.size());
        else n_pass++;
        n_total++;
        if (irq !== 2'b01) $display("FAIL err_irq: got %b, required 01", irq); else n_pass++;
        reg_write(RA_W'(3), 32'h4);
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h0) $display("FAIL err_clr_status: got %h, required 0", d); else n_pass++;
        n_total++;
        if (irq !== 2'b00) $display("FAIL err_clr_irq: got %b, required 00", irq); else n_pass++;
        reg_write(RA_W'(0), 32'h0);
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int k;
        clear_logs();
        put_desc(32'h40, 32'h100, 32'h200, 32'd32, 32'h1);
        for (int i = 0; i < 3; i++) exp_q.push_back({32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
        reg_write(RA_W'(1), 32'h40);
        reg_write(RA_W'(0), 32'h3);
        k = 0;
        while (wr_addr_q.size() < 2 && k < 500) begin @(negedge clk); k++; end
        hold_w = 1'b1;
        k = 0;
        while (!W_req && k < 100) begin @(negedge clk); k++; end
        n_total++;
        if (W_req !== 1'b1 || wr_addr_q.size() !== 2)
            $display("FAIL abort_third_beat: got W_req=%0b writes=%0d, required 1 / 2", W_req, wr_addr_q.size());
        else n_pass++;
        reg_write(RA_W'(0), 32'h2);
        hold_w = 1'b0;
        wait_idle(0, "abort");
        repeat (10) @(negedge clk);
        n_total++;
        if (wr_addr_q.size() !== exp_q.size())
            $display("FAIL abort_beats: got %0d writes, required %0d", wr_addr_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
            n_total++;
            if ({wr_addr_q[i], wr_data_q[i]} !== exp_q[i])
                $display("FAIL abort_wr%0d: got %h/%h, required %h", i, wr_addr_q[i], wr_data_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (rd_addr_q.size() !== 7) $display("FAIL abort_reads: got %0d, required 7", rd_addr_q.size()); else n_pass++;
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h8) $display("FAIL abort_status: got %h, required 8", d); else n_pass++;
        n_total++;
        if (irq !== 2'b01) $display("FAIL abort_irq: got %b, required 01", irq); else n_pass++;
        reg_write(RA_W'(3), 32'h8);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int k;
        bit seen_req;
        clear_logs();
        put_desc(32'h40, 32'h120, 32'h240, 32'd16, 32'h1);
        hold_w = 1'b1;
        reg_write(RA_W'(1), 32'h40);
        reg_write(RA_W'(0), 32'h3);
        k = 0;
        while (!W_req && k < 200) begin @(negedge clk); k++; end
        n_total++;
        if (W_req !== 1'b1) $display("FAIL rstmid_wreq_seen: got %0b, required 1", W_req); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({R_req, W_req, irq, DO} !== '0)
            $display("FAIL rstmid_async: got R=%0b W=%0b irq=%b DO=%h, required all 0", R_req, W_req, irq, DO);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_w = 1'b0;
        seen_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (R_req || W_req) seen_req = 1'b1;
        end
        n_total++;
        if (seen_req !== 1'b0) $display("FAIL rstmid_quiet: got req activity=%0b, required 0", seen_req); else n_pass++;
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rstmid_status: got %h, required 0", d); else n_pass++;
        reg_read(RA_W'(1), d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rstmid_base: got %h, required 0", d); else n_pass++;
        clear_logs();
        for (int i = 0; i < 4; i++) exp_q.push_back({32'h240 + 32'(4 * i), 32'hA000_0008 + 32'(i)});
        reg_write(RA_W'(1), 32'h40);
        reg_write(RA_W'(0), 32'h3);
        wait_idle(0, "rstmid_rerun");
        n_total++;
        if (wr_addr_q.size() !== exp_q.size())
            $display("FAIL rstmid_beats: got %0d writes, required %0d", wr_addr_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
            n_total++;
            if ({wr_addr_q[i], wr_data_q[i]} !== exp_q[i])
                $display("FAIL rstmid_wr%0d: got %h/%h, required %h", i, wr_addr_q[i], wr_data_q[i], exp_q[i]);
            else n_pass++;
        end
        reg_read(RA_W'(2), d);
        n_total++;
        if (d !== 32'h2) $display("FAIL rstmid_done: got %h, required 2", d); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        CEB = 1'b1; WEB = 1'b1; A = '0; DI = '0;
        hold_w = 1'b0;
        n_total = 0; n_pass = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 64; i++) mem[64 + i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_single();
        test_chain();
        test_round_robin();
        test_len_err();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
